toy_agu_pipe: RTL and testbench
===============================

Name: toy_agu_pipe

Overview:
- Parametrised, registered address-generation unit between the LSU issue stage and the memory request port.
- Computes effective address (rs1 + imm), byte strobe and lane-aligned store data for any DATA_WIDTH.
- Splits accesses that cross a DATA_WIDTH/8-byte boundary into two bus beats.
- Holds one outstanding request in an output register with valid/ready backpressure and a flush input.

Parameters:
- ADDR_WIDTH, 32, effective address width.
- DATA_WIDTH, 32, bus data width; 32 or 64. BYTES = DATA_WIDTH/8, OFS = log2(BYTES).
- ID_WIDTH, 6, instruction id width.
- RD_WIDTH, 6, destination register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_flush  in  1  pipeline flush; drops the held and in-progress request
- s_vld  in  1  request valid
- s_rdy  out  1  request accepted when s_vld & s_rdy
- s_rs1_val  in  ADDR_WIDTH  base register
- s_imm  in  ADDR_WIDTH  sign-extended immediate
- s_rs2_val  in  DATA_WIDTH  store data
- s_is_store  in  1  1 = store, 0 = load
- s_funct3  in  3  size/sign: [1:0] 0 = B, 1 = H, 2 = W, 3 = D
- s_inst_id  in  ID_WIDTH  instruction id
- s_rd  in  RD_WIDTH  destination index
- s_rd_en  in  1  integer rd write
- s_fp_rd_en  in  1  fp rd write
- m_vld  out  1  bus request valid
- m_rdy  in  1  bus ready
- m_opcode  out  1  TOY_BUS_WRITE if store, else TOY_BUS_READ
- m_addr  out  ADDR_WIDTH  beat address, always BYTES-aligned
- m_data  out  DATA_WIDTH  lane-shifted store data
- m_strb  out  BYTES  byte enables
- m_offset  out  OFS  original address offset within the beat
- m_first  out  1  first or only beat
- m_last  out  1  last or only beat
- m_exc  out  1  illegal size or misaligned access (no memory effect)
- m_inst_id, m_rd, m_rd_en, m_fp_rd_en, m_funct3  out  as inputs  registered sideband

Behaviour:
- Reset: m_vld = 0, state = IDLE, all payload registers 0.
- ea = s_rs1_val + s_imm, mod 2^ADDR_WIDTH. ofs = ea[OFS-1:0].
- Size mask: B = 1, H = 3, W = 0xF, D = 0xFF.
  - D with DATA_WIDTH = 32 is illegal: m_exc = 1, m_strb = 0, single beat.
- wide_strb (2*BYTES bits) = mask << ofs. wide_data (2*DATA_WIDTH bits) = s_rs2_val << (8*ofs).
- cross = |wide_strb[2*BYTES-1:BYTES].
- Latency: accepted request appears on m_* the next cycle. The output register updates only when empty or when m_vld & m_rdy.
- FSM IDLE:
  - s_rdy = ~m_vld | m_rdy.
  - On accept, load beat0:
    - addr = {ea[ADDR_WIDTH-1:OFS], 0}
    - strb = wide_strb low half
    - data = wide_data low half
    - m_first = 1; m_last = ~cross
  - If cross (split enabled), also latch beat1 into a spare register (strb high half, data high half, addr + BYTES with wrap) and go to SPLIT.
- FSM SPLIT:
  - s_rdy = 0.
  - When beat0 handshakes, load beat1 with m_first = 0, m_last = 1 and return to IDLE. A new request can be accepted the cycle beat1 handshakes.
- Loads carry the same strb and addr; m_data is don't-care but driven by the shift.
- Payload is stable while m_vld & ~m_rdy.
- s_flush (priority over everything except reset):
  - Next cycle m_vld = 0 and state = IDLE.
  - A request presented in the flush cycle is not accepted; s_rdy = 0 that cycle.
- Simultaneous beat0 handshake and flush: flush wins, beat1 is never issued.
- Reset mid-split: returns to IDLE, m_vld = 0 immediately (async).

Optional Feature:
- TOY_AGU_MISALIGN_SPLIT_EN defined: crossing accesses are split as above.
- Not defined: a crossing access is issued as a single beat with m_exc = 1, m_strb = 0, m_first = m_last = 1. SPLIT state and spare register are not built.

Test Plan:
- DATA_WIDTH = 32, load W, rs1 = 0x1000, imm = 4 -> one beat next cycle: addr 0x1004, strb 0xF, first = last = 1, opcode READ.
- Store H, rs1 = 0x2001, imm = 0, rs2 = 0x0000ABCD -> addr 0x2000, strb 0x6, data 0x00ABCD00, offset 1.
- Split enabled, store W at 0x3003, rs2 = 0x11223344:
  - beat0: addr 0x3000, strb 0x8, data 0x44000000, first = 1, last = 0
  - beat1: addr 0x3004, strb 0x7, data 0x00112233, last = 1
  - s_rdy = 0 until beat1 handshakes.
- Same access with split disabled -> single beat, m_exc = 1, strb 0. Separately, D size on 32-bit -> m_exc = 1.
- Hold m_rdy = 0 for 5 cycles with m_vld = 1 -> payload stable, s_rdy = 0. Assert s_flush in SPLIT after beat0 -> m_vld = 0 next cycle, no beat1.
- DATA_WIDTH = 64, load D at 0xFFFFFFFC (split enabled) -> beat0 addr 0xFFFFFFF8 strb 0xF0; beat1 addr 0x00000000 strb 0x0F (wrap).

Source files
------------

// File: rtl/toy_agu_pipe.sv
// toy_agu_pipe: registered address-generation unit for the LSU.
// Computes the effective address, byte strobe and lane-shifted store data,
// and presents the request on a valid/ready bus through one output register.
// Accesses that run past a BYTES-aligned beat are split into two beats when
// TOY_AGU_MISALIGN_SPLIT_EN is defined; otherwise they are issued as a single
// beat flagged with m_exc and no byte enables.

module toy_agu_pipe #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 6,
    parameter int RD_WIDTH   = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_flush,
    input  logic                      s_vld,
    output logic                      s_rdy,
    input  logic [ADDR_WIDTH-1:0]     s_rs1_val,
    input  logic [ADDR_WIDTH-1:0]     s_imm,
    input  logic [DATA_WIDTH-1:0]     s_rs2_val,
    input  logic                      s_is_store,
    input  logic [2:0]                s_funct3,
    input  logic [ID_WIDTH-1:0]       s_inst_id,
    input  logic [RD_WIDTH-1:0]       s_rd,
    input  logic                      s_rd_en,
    input  logic                      s_fp_rd_en,
    output logic                      m_vld,
    input  logic                      m_rdy,
    output logic                      m_opcode,
    output logic [ADDR_WIDTH-1:0]     m_addr,
    output logic [DATA_WIDTH-1:0]     m_data,
    output logic [DATA_WIDTH/8-1:0]   m_strb,
    output logic [$clog2(DATA_WIDTH/8)-1:0] m_offset,
    output logic                      m_first,
    output logic                      m_last,
    output logic                      m_exc,
    output logic [ID_WIDTH-1:0]       m_inst_id,
    output logic [RD_WIDTH-1:0]       m_rd,
    output logic                      m_rd_en,
    output logic                      m_fp_rd_en,
    output logic [2:0]                m_funct3
);

    localparam int   BYTES         = DATA_WIDTH / 8;
    localparam int   OFS           = $clog2(BYTES);
    localparam logic TOY_BUS_READ  = 1'b0;
    localparam logic TOY_BUS_WRITE = 1'b1;
    // A doubleword only fits when the bus is at least 8 bytes wide.
    localparam logic D_LEGAL       = (BYTES >= 8) ? 1'b1 : 1'b0;

    // Byte mask of an access of the given size, before shifting into lanes.
    function automatic logic [2*BYTES-1:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            2'd3:    m = 8'hFF;
            default: m = 8'h00;
        endcase
        return (2*BYTES)'(m);
    endfunction

    // ------------------------------------------------------------------
    // Address / strobe / data computation for the presented request
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]  ea_s;
    logic [OFS-1:0]         ofs_s;
    logic [2*BYTES-1:0]     wide_strb_s;
    logic                   illegal_s;
    logic                   cross_s;
    logic [ADDR_WIDTH-1:0]  addr0_s;
    logic [BYTES-1:0]       strb0_s;
    logic [DATA_WIDTH-1:0]  data0_s;
    logic                   exc0_s;
    logic                   last0_s;

    assign ea_s        = s_rs1_val + s_imm;
    assign ofs_s       = ea_s[OFS-1:0];
    assign wide_strb_s = size_mask(s_funct3[1:0]) << ofs_s;
    assign illegal_s   = (s_funct3[1:0] == 2'd3) & ~D_LEGAL;
    // An illegal size never produces a second beat.
    assign cross_s     = (|wide_strb_s[2*BYTES-1:BYTES]) & ~illegal_s;
    assign addr0_s     = {ea_s[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};

`ifdef TOY_AGU_MISALIGN_SPLIT_EN
    logic [2*DATA_WIDTH-1:0] wide_data_s;
    assign wide_data_s = {{DATA_WIDTH{1'b0}}, s_rs2_val} << {ofs_s, 3'b000};
    assign data0_s     = wide_data_s[DATA_WIDTH-1:0];
    assign exc0_s      = illegal_s;
    assign last0_s     = ~cross_s;
`else
    // Only the low beat is ever issued, so the spill-over bits are dropped.
    assign data0_s     = s_rs2_val << {ofs_s, 3'b000};
    assign exc0_s      = illegal_s | cross_s;
    assign last0_s     = 1'b1;
`endif

    assign strb0_s = exc0_s ? {BYTES{1'b0}} : wide_strb_s[BYTES-1:0];

    // ------------------------------------------------------------------
    // Control: accept / load decisions
    // ------------------------------------------------------------------
    logic s_rdy_s;
    logic ld0_s;
    logic vld_nxt_s;
    logic m_vld_r;

`ifdef TOY_AGU_MISALIGN_SPLIT_EN
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic                   ld1_s;
    logic [ADDR_WIDTH-1:0]  spare_addr_r;
    logic [BYTES-1:0]       spare_strb_r;
    logic [DATA_WIDTH-1:0]  spare_data_r;

    // Next-state and handshake decode; flush overrides any progress.
    always_comb begin
        state_nxt_s = state_r;
        s_rdy_s     = 1'b0;
        ld0_s       = 1'b0;
        ld1_s       = 1'b0;
        vld_nxt_s   = m_vld_r;
        if (s_flush) begin
            state_nxt_s = ST_IDLE;
            vld_nxt_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    s_rdy_s = ~m_vld_r | m_rdy;
                    if (s_rdy_s) begin
                        vld_nxt_s   = s_vld;
                        ld0_s       = s_vld;
                        state_nxt_s = (s_vld & cross_s) ? ST_SPLIT : ST_IDLE;
                    end else begin
                        vld_nxt_s   = m_vld_r;
                    end
                end
                ST_SPLIT: begin
                    if (m_rdy) begin
                        ld1_s       = 1'b1;
                        vld_nxt_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_SPLIT;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    vld_nxt_s   = 1'b0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Spare register holding the second beat of a split access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spare_addr_r <= {ADDR_WIDTH{1'b0}};
            spare_strb_r <= {BYTES{1'b0}};
            spare_data_r <= {DATA_WIDTH{1'b0}};
        end else if (ld0_s & cross_s) begin
            spare_addr_r <= addr0_s + ADDR_WIDTH'(BYTES);
            spare_strb_r <= wide_strb_s[2*BYTES-1:BYTES];
            spare_data_r <= wide_data_s[2*DATA_WIDTH-1:DATA_WIDTH];
        end else begin
            spare_addr_r <= spare_addr_r;
            spare_strb_r <= spare_strb_r;
            spare_data_r <= spare_data_r;
        end
    end
`else
    // Handshake decode for single-beat operation; flush overrides any progress.
    always_comb begin
        s_rdy_s   = 1'b0;
        ld0_s     = 1'b0;
        vld_nxt_s = m_vld_r;
        if (s_flush) begin
            vld_nxt_s = 1'b0;
        end else begin
            s_rdy_s = ~m_vld_r | m_rdy;
            if (s_rdy_s) begin
                vld_nxt_s = s_vld;
                ld0_s     = s_vld;
            end else begin
                vld_nxt_s = m_vld_r;
            end
        end
    end
`endif

    assign s_rdy = s_rdy_s;

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic                   m_opcode_r;
    logic [ADDR_WIDTH-1:0]  m_addr_r;
    logic [DATA_WIDTH-1:0]  m_data_r;
    logic [BYTES-1:0]       m_strb_r;
    logic [OFS-1:0]         m_offset_r;
    logic                   m_first_r;
    logic                   m_last_r;
    logic                   m_exc_r;
    logic [ID_WIDTH-1:0]    m_inst_id_r;
    logic [RD_WIDTH-1:0]    m_rd_r;
    logic                   m_rd_en_r;
    logic                   m_fp_rd_en_r;
    logic [2:0]             m_funct3_r;

    // Request valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld_r <= 1'b0;
        end else begin
            m_vld_r <= vld_nxt_s;
        end
    end

    // Beat payload: first beat on accept, spare beat when the split continues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_opcode_r   <= TOY_BUS_READ;
            m_addr_r     <= {ADDR_WIDTH{1'b0}};
            m_data_r     <= {DATA_WIDTH{1'b0}};
            m_strb_r     <= {BYTES{1'b0}};
            m_offset_r   <= {OFS{1'b0}};
            m_first_r    <= 1'b0;
            m_last_r     <= 1'b0;
            m_exc_r      <= 1'b0;
            m_inst_id_r  <= {ID_WIDTH{1'b0}};
            m_rd_r       <= {RD_WIDTH{1'b0}};
            m_rd_en_r    <= 1'b0;
            m_fp_rd_en_r <= 1'b0;
            m_funct3_r   <= 3'd0;
        end else if (ld0_s) begin
            m_opcode_r   <= s_is_store ? TOY_BUS_WRITE : TOY_BUS_READ;
            m_addr_r     <= addr0_s;
            m_data_r     <= data0_s;
            m_strb_r     <= strb0_s;
            m_offset_r   <= ofs_s;
            m_first_r    <= 1'b1;
            m_last_r     <= last0_s;
            m_exc_r      <= exc0_s;
            m_inst_id_r  <= s_inst_id;
            m_rd_r       <= s_rd;
            m_rd_en_r    <= s_rd_en;
            m_fp_rd_en_r <= s_fp_rd_en;
            m_funct3_r   <= s_funct3;
`ifdef TOY_AGU_MISALIGN_SPLIT_EN
        end else if (ld1_s) begin
            // Sideband, opcode and offset stay with the original request.
            m_addr_r     <= spare_addr_r;
            m_data_r     <= spare_data_r;
            m_strb_r     <= spare_strb_r;
            m_first_r    <= 1'b0;
            m_last_r     <= 1'b1;
            m_exc_r      <= 1'b0;
`endif
        end else begin
            m_opcode_r   <= m_opcode_r;
            m_addr_r     <= m_addr_r;
            m_data_r     <= m_data_r;
            m_strb_r     <= m_strb_r;
            m_offset_r   <= m_offset_r;
            m_first_r    <= m_first_r;
            m_last_r     <= m_last_r;
            m_exc_r      <= m_exc_r;
            m_inst_id_r  <= m_inst_id_r;
            m_rd_r       <= m_rd_r;
            m_rd_en_r    <= m_rd_en_r;
            m_fp_rd_en_r <= m_fp_rd_en_r;
            m_funct3_r   <= m_funct3_r;
        end
    end

    assign m_vld      = m_vld_r;
    assign m_opcode   = m_opcode_r;
    assign m_addr     = m_addr_r;
    assign m_data     = m_data_r;
    assign m_strb     = m_strb_r;
    assign m_offset   = m_offset_r;
    assign m_first    = m_first_r;
    assign m_last     = m_last_r;
    assign m_exc      = m_exc_r;
    assign m_inst_id  = m_inst_id_r;
    assign m_rd       = m_rd_r;
    assign m_rd_en    = m_rd_en_r;
    assign m_fp_rd_en = m_fp_rd_en_r;
    assign m_funct3   = m_funct3_r;

endmodule

// File: tb/tb_toy_agu_pipe.sv
// Directed testbench for toy_agu_pipe: a 32-bit and a 64-bit instance.
// Expectations follow TOY_AGU_MISALIGN_SPLIT_EN when it is defined.

module tb_toy_agu_pipe;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    // 32-bit instance signals
    logic        s_flush, s_vld, s_rdy, s_is_store, s_rd_en, s_fp_rd_en;
    logic [31:0] s_rs1_val, s_imm, s_rs2_val;
    logic [2:0]  s_funct3;
    logic [5:0]  s_inst_id, s_rd;
    logic        m_vld, m_rdy, m_opcode, m_first, m_last, m_exc, m_rd_en, m_fp_rd_en;
    logic [31:0] m_addr, m_data;
    logic [3:0]  m_strb;
    logic [1:0]  m_offset;
    logic [5:0]  m_inst_id, m_rd;
    logic [2:0]  m_funct3;

    // 64-bit instance signals
    logic        w_s_flush, w_s_vld, w_s_rdy, w_s_is_store, w_s_rd_en, w_s_fp_rd_en;
    logic [31:0] w_s_rs1_val, w_s_imm;
    logic [63:0] w_s_rs2_val;
    logic [2:0]  w_s_funct3;
    logic [5:0]  w_s_inst_id, w_s_rd;
    logic        w_m_vld, w_m_rdy, w_m_opcode, w_m_first, w_m_last, w_m_exc, w_m_rd_en, w_m_fp_rd_en;
    logic [31:0] w_m_addr;
    logic [63:0] w_m_data;
    logic [7:0]  w_m_strb;
    logic [2:0]  w_m_offset;
    logic [5:0]  w_m_inst_id, w_m_rd;
    logic [2:0]  w_m_funct3;

    toy_agu_pipe #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(6), .RD_WIDTH(6)) dut (
        .clk(clk), .rst_n(rst_n), .s_flush(s_flush), .s_vld(s_vld), .s_rdy(s_rdy),
        .s_rs1_val(s_rs1_val), .s_imm(s_imm), .s_rs2_val(s_rs2_val), .s_is_store(s_is_store),
        .s_funct3(s_funct3), .s_inst_id(s_inst_id), .s_rd(s_rd), .s_rd_en(s_rd_en),
        .s_fp_rd_en(s_fp_rd_en), .m_vld(m_vld), .m_rdy(m_rdy), .m_opcode(m_opcode),
        .m_addr(m_addr), .m_data(m_data), .m_strb(m_strb), .m_offset(m_offset),
        .m_first(m_first), .m_last(m_last), .m_exc(m_exc), .m_inst_id(m_inst_id),
        .m_rd(m_rd), .m_rd_en(m_rd_en), .m_fp_rd_en(m_fp_rd_en), .m_funct3(m_funct3)
    );

    toy_agu_pipe #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(6), .RD_WIDTH(6)) dut_w (
        .clk(clk), .rst_n(rst_n), .s_flush(w_s_flush), .s_vld(w_s_vld), .s_rdy(w_s_rdy),
        .s_rs1_val(w_s_rs1_val), .s_imm(w_s_imm), .s_rs2_val(w_s_rs2_val), .s_is_store(w_s_is_store),
        .s_funct3(w_s_funct3), .s_inst_id(w_s_inst_id), .s_rd(w_s_rd), .s_rd_en(w_s_rd_en),
        .s_fp_rd_en(w_s_fp_rd_en), .m_vld(w_m_vld), .m_rdy(w_m_rdy), .m_opcode(w_m_opcode),
        .m_addr(w_m_addr), .m_data(w_m_data), .m_strb(w_m_strb), .m_offset(w_m_offset),
        .m_first(w_m_first), .m_last(w_m_last), .m_exc(w_m_exc), .m_inst_id(w_m_inst_id),
        .m_rd(w_m_rd), .m_rd_en(w_m_rd_en), .m_fp_rd_en(w_m_fp_rd_en), .m_funct3(w_m_funct3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] rs1,
                         input logic [31:0] imm, input logic [31:0] rs2, input logic [5:0] id);
        s_vld = 1'b1; s_is_store = st; s_funct3 = f3; s_rs1_val = rs1; s_imm = imm;
        s_rs2_val = rs2; s_inst_id = id; s_rd = 6'd3; s_rd_en = ~st; s_fp_rd_en = 1'b0;
        #1;
    endtask

    task automatic drive_w(input logic st, input logic [2:0] f3, input logic [31:0] rs1,
                           input logic [63:0] rs2);
        w_s_vld = 1'b1; w_s_is_store = st; w_s_funct3 = f3; w_s_rs1_val = rs1;
        w_s_imm = 32'h0; w_s_rs2_val = rs2; w_s_inst_id = 6'd1; w_s_rd = 6'd2;
        w_s_rd_en = ~st; w_s_fp_rd_en = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_chk++; if (m_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got=%b exp=0", m_vld); end
        n_chk++; if (m_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", m_addr); end
        n_chk++; if (m_strb !== 4'h0) begin n_fail++; $display("FAIL reset_strb got=%h exp=0", m_strb); end
        n_chk++; if (m_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", m_data); end
        n_chk++; if (w_m_vld !== 1'b0) begin n_fail++; $display("FAIL reset_w_vld got=%b exp=0", w_m_vld); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_w();
        m_rdy = 1'b1;
        drive(1'b0, 3'd2, 32'h1000, 32'h4, 32'hDEADBEEF, 6'd5);
        n_chk++; if (s_rdy !== 1'b1) begin n_fail++; $display("FAIL load_w_srdy got=%b exp=1", s_rdy); end
        tick(); s_vld = 1'b0;
        n_chk++; if (m_vld !== 1'b1) begin n_fail++; $display("FAIL load_w_vld got=%b exp=1", m_vld); end
        n_chk++; if (m_addr !== 32'h1004) begin n_fail++; $display("FAIL load_w_addr got=%h exp=00001004", m_addr); end
        n_chk++; if (m_strb !== 4'hF) begin n_fail++; $display("FAIL load_w_strb got=%h exp=f", m_strb); end
        n_chk++; if (m_first !== 1'b1 || m_last !== 1'b1) begin n_fail++; $display("FAIL load_w_firstlast got=%b%b exp=11", m_first, m_last); end
        n_chk++; if (m_opcode !== 1'b0) begin n_fail++; $display("FAIL load_w_opcode got=%b exp=0", m_opcode); end
        n_chk++; if (m_exc !== 1'b0) begin n_fail++; $display("FAIL load_w_exc got=%b exp=0", m_exc); end
        n_chk++; if (m_inst_id !== 6'd5 || m_rd !== 6'd3 || m_rd_en !== 1'b1 || m_fp_rd_en !== 1'b0 || m_funct3 !== 3'd2) begin
            n_fail++; $display("FAIL load_w_sideband got=%0d/%0d/%b/%b/%0d exp=5/3/1/0/2", m_inst_id, m_rd, m_rd_en, m_fp_rd_en, m_funct3); end
        tick();
        n_chk++; if (m_vld !== 1'b0) begin n_fail++; $display("FAIL load_w_drain got=%b exp=0", m_vld); end
    endtask

    task automatic test_store_h();
        drive(1'b1, 3'd1, 32'h2001, 32'h0, 32'h0000ABCD, 6'd6);
        tick(); s_vld = 1'b0;
        n_chk++; if (m_addr !== 32'h2000) begin n_fail++; $display("FAIL store_h_addr got=%h exp=00002000", m_addr); end
        n_chk++; if (m_strb !== 4'h6) begin n_fail++; $display("FAIL store_h_strb got=%h exp=6", m_strb); end
        n_chk++; if (m_data !== 32'h00ABCD00) begin n_fail++; $display("FAIL store_h_data got=%h exp=00abcd00", m_data); end
        n_chk++; if (m_offset !== 2'd1) begin n_fail++; $display("FAIL store_h_offset got=%0d exp=1", m_offset); end
        n_chk++; if (m_opcode !== 1'b1 || m_exc !== 1'b0 || m_last !== 1'b1) begin
            n_fail++; $display("FAIL store_h_flags got=%b%b%b exp=101", m_opcode, m_exc, m_last); end
        tick();
    endtask

    task automatic test_cross();
        m_rdy = 1'b1;
        drive(1'b1, 3'd2, 32'h3003, 32'h0, 32'h11223344, 6'd7);
        tick(); s_vld = 1'b0;
`ifdef TOY_AGU_MISALIGN_SPLIT_EN
        n_chk++; if (m_addr !== 32'h3000 || m_strb !== 4'h8) begin n_fail++; $display("FAIL split_b0_addrstrb got=%h/%h exp=00003000/8", m_addr, m_strb); end
        n_chk++; if (m_data !== 32'h44000000) begin n_fail++; $display("FAIL split_b0_data got=%h exp=44000000", m_data); end
        n_chk++; if (m_first !== 1'b1 || m_last !== 1'b0 || m_exc !== 1'b0) begin n_fail++; $display("FAIL split_b0_flags got=%b%b%b exp=100", m_first, m_last, m_exc); end
        n_chk++; if (s_rdy !== 1'b0) begin n_fail++; $display("FAIL split_b0_srdy got=%b exp=0", s_rdy); end
        tick();
        n_chk++; if (m_vld !== 1'b1 || m_addr !== 32'h3004 || m_strb !== 4'h7) begin n_fail++; $display("FAIL split_b1_addrstrb got=%b/%h/%h exp=1/00003004/7", m_vld, m_addr, m_strb); end
        n_chk++; if (m_data !== 32'h00112233) begin n_fail++; $display("FAIL split_b1_data got=%h exp=00112233", m_data); end
        n_chk++; if (m_first !== 1'b0 || m_last !== 1'b1 || m_inst_id !== 6'd7) begin n_fail++; $display("FAIL split_b1_flags got=%b%b/%0d exp=01/7", m_first, m_last, m_inst_id); end
        n_chk++; if (s_rdy !== 1'b1) begin n_fail++; $display("FAIL split_b1_srdy got=%b exp=1", s_rdy); end
        // Back-to-back: accept a new request in the cycle beat1 handshakes.
        drive(1'b0, 3'd2, 32'h1000, 32'h0, 32'h0, 6'd8);
        tick(); s_vld = 1'b0;
        n_chk++; if (m_addr !== 32'h1000 || m_first !== 1'b1 || m_last !== 1'b1 || m_inst_id !== 6'd8) begin
            n_fail++; $display("FAIL b2b_beat got=%h/%b%b/%0d exp=00001000/11/8", m_addr, m_first, m_last, m_inst_id); end
`else
        n_chk++; if (m_exc !== 1'b1 || m_strb !== 4'h0) begin n_fail++; $display("FAIL cross_nosplit_exc got=%b/%h exp=1/0", m_exc, m_strb); end
        n_chk++; if (m_first !== 1'b1 || m_last !== 1'b1 || m_addr !== 32'h3000) begin n_fail++; $display("FAIL cross_nosplit_beat got=%b%b/%h exp=11/00003000", m_first, m_last, m_addr); end
        n_chk++; if (s_rdy !== 1'b1) begin n_fail++; $display("FAIL cross_nosplit_srdy got=%b exp=1", s_rdy); end
        tick();
        n_chk++; if (m_vld !== 1'b0) begin n_fail++; $display("FAIL cross_nosplit_single got=%b exp=0", m_vld); end
`endif
        tick();
    endtask

    task automatic test_illegal_d();
        drive(1'b0, 3'd3, 32'h4000, 32'h0, 32'h0, 6'd9);
        tick(); s_vld = 1'b0;
        n_chk++; if (m_exc !== 1'b1 || m_strb !== 4'h0) begin n_fail++; $display("FAIL illegal_d_exc got=%b/%h exp=1/0", m_exc, m_strb); end
        n_chk++; if (m_first !== 1'b1 || m_last !== 1'b1) begin n_fail++; $display("FAIL illegal_d_beat got=%b%b exp=11", m_first, m_last); end
        tick();
        n_chk++; if (m_vld !== 1'b0) begin n_fail++; $display("FAIL illegal_d_single got=%b exp=0", m_vld); end
    endtask

    task automatic test_backpressure();
        m_rdy = 1'b0;
        drive(1'b0, 3'd2, 32'h5000, 32'h8, 32'h0, 6'd9);
        tick();
        drive(1'b0, 3'd2, 32'h6000, 32'h0, 32'h0, 6'd10);
        for (int i = 0; i < 5; i++) begin
            n_chk++; if (m_vld !== 1'b1 || m_addr !== 32'h5008 || m_inst_id !== 6'd9) begin
                n_fail++; $display("FAIL hold_payload cyc=%0d got=%b/%h/%0d exp=1/00005008/9", i, m_vld, m_addr, m_inst_id); end
            n_chk++; if (s_rdy !== 1'b0) begin n_fail++; $display("FAIL hold_srdy cyc=%0d got=%b exp=0", i, s_rdy); end
            tick();
        end
        m_rdy = 1'b1; #1;
        n_chk++; if (s_rdy !== 1'b1) begin n_fail++; $display("FAIL release_srdy got=%b exp=1", s_rdy); end
        tick(); s_vld = 1'b0;
        n_chk++; if (m_addr !== 32'h6000 || m_inst_id !== 6'd10) begin n_fail++; $display("FAIL release_next got=%h/%0d exp=00006000/10", m_addr, m_inst_id); end
        tick();
    endtask

    task automatic test_flush();
        m_rdy = 1'b0;
        drive(1'b0, 3'd2, 32'h7000, 32'h0, 32'h0, 6'd11);
        tick();
        s_flush = 1'b1;
        drive(1'b0, 3'd2, 32'h7100, 32'h0, 32'h0, 6'd12);
        n_chk++; if (s_rdy !== 1'b0) begin n_fail++; $display("FAIL flush_srdy got=%b exp=0", s_rdy); end
        tick(); s_flush = 1'b0; s_vld = 1'b0; m_rdy = 1'b1;
        n_chk++; if (m_vld !== 1'b0) begin n_fail++; $display("FAIL flush_drop got=%b exp=0", m_vld); end
        tick();
        n_chk++; if (m_vld !== 1'b0) begin n_fail++; $display("FAIL flush_noaccept got=%b exp=0", m_vld); end
`ifdef TOY_AGU_MISALIGN_SPLIT_EN
        // Flush in the same cycle beat0 handshakes: beat1 must never appear.
        drive(1'b1, 3'd2, 32'h3003, 32'h0, 32'h11223344, 6'd13);
        tick(); s_vld = 1'b0;
        n_chk++; if (m_first !== 1'b1 || m_last !== 1'b0) begin n_fail++; $display("FAIL flush_split_b0 got=%b%b exp=10", m_first, m_last); end
        s_flush = 1'b1;
        drive(1'b0, 3'd2, 32'h7200, 32'h0, 32'h0, 6'd14);
        n_chk++; if (s_rdy !== 1'b0) begin n_fail++; $display("FAIL flush_split_srdy got=%b exp=0", s_rdy); end
        tick(); s_flush = 1'b0; s_vld = 1'b0;
        n_chk++; if (m_vld !== 1'b0) begin n_fail++; $display("FAIL flush_split_drop got=%b exp=0", m_vld); end
        tick();
        n_chk++; if (m_vld !== 1'b0) begin n_fail++; $display("FAIL flush_split_nob1 got=%b exp=0", m_vld); end
`endif
    endtask

    task automatic test_reset_mid();
        m_rdy = 1'b0;
        drive(1'b1, 3'd2, 32'h3003, 32'h0, 32'h11223344, 6'd15);
        tick(); s_vld = 1'b0;
        n_chk++; if (m_vld !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got=%b exp=1", m_vld); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (m_vld !== 1'b0 || m_addr !== 32'h0) begin n_fail++; $display("FAIL rstmid_async got=%b/%h exp=0/00000000", m_vld, m_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        m_rdy = 1'b1;
        drive(1'b0, 3'd2, 32'h1000, 32'h10, 32'h0, 6'd16);
        n_chk++; if (s_rdy !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle_srdy got=%b exp=1", s_rdy); end
        tick(); s_vld = 1'b0;
        n_chk++; if (m_addr !== 32'h1010 || m_first !== 1'b1 || m_last !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_next got=%h/%b%b exp=00001010/11", m_addr, m_first, m_last); end
        tick();
    endtask

    task automatic test_wide();
        w_m_rdy = 1'b1;
        drive_w(1'b1, 3'd3, 32'h100, 64'h1122334455667788);
        tick(); w_s_vld = 1'b0;
        n_chk++; if (w_m_addr !== 32'h100 || w_m_strb !== 8'hFF || w_m_exc !== 1'b0) begin
            n_fail++; $display("FAIL wide_d_beat got=%h/%h/%b exp=00000100/ff/0", w_m_addr, w_m_strb, w_m_exc); end
        n_chk++; if (w_m_data !== 64'h1122334455667788) begin n_fail++; $display("FAIL wide_d_data got=%h exp=1122334455667788", w_m_data); end
        tick();
        drive_w(1'b1, 3'd2, 32'h104, 64'h00000000AABBCCDD);
        tick(); w_s_vld = 1'b0;
        n_chk++; if (w_m_addr !== 32'h100 || w_m_strb !== 8'hF0 || w_m_offset !== 3'd4) begin
            n_fail++; $display("FAIL wide_w_beat got=%h/%h/%0d exp=00000100/f0/4", w_m_addr, w_m_strb, w_m_offset); end
        n_chk++; if (w_m_data !== 64'hAABBCCDD00000000) begin n_fail++; $display("FAIL wide_w_data got=%h exp=aabbccdd00000000", w_m_data); end
        tick();
        drive_w(1'b0, 3'd3, 32'hFFFFFFFC, 64'h0);
        tick(); w_s_vld = 1'b0;
`ifdef TOY_AGU_MISALIGN_SPLIT_EN
        n_chk++; if (w_m_addr !== 32'hFFFFFFF8 || w_m_strb !== 8'hF0 || w_m_first !== 1'b1 || w_m_last !== 1'b0) begin
            n_fail++; $display("FAIL wide_wrap_b0 got=%h/%h/%b%b exp=fffffff8/f0/10", w_m_addr, w_m_strb, w_m_first, w_m_last); end
        tick();
        n_chk++; if (w_m_vld !== 1'b1 || w_m_addr !== 32'h0 || w_m_strb !== 8'h0F || w_m_first !== 1'b0 || w_m_last !== 1'b1) begin
            n_fail++; $display("FAIL wide_wrap_b1 got=%b/%h/%h/%b%b exp=1/00000000/0f/01", w_m_vld, w_m_addr, w_m_strb, w_m_first, w_m_last); end
`else
        n_chk++; if (w_m_addr !== 32'hFFFFFFF8 || w_m_strb !== 8'h00 || w_m_exc !== 1'b1 || w_m_last !== 1'b1) begin
            n_fail++; $display("FAIL wide_wrap_exc got=%h/%h/%b%b exp=fffffff8/00/11", w_m_addr, w_m_strb, w_m_exc, w_m_last); end
`endif
        tick();
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; m_rdy = 1'b0; s_flush = 1'b0; s_vld = 1'b0;
        s_rs1_val = 32'h0; s_imm = 32'h0; s_rs2_val = 32'h0; s_is_store = 1'b0;
        s_funct3 = 3'd0; s_inst_id = 6'd0; s_rd = 6'd0; s_rd_en = 1'b0; s_fp_rd_en = 1'b0;
        w_m_rdy = 1'b0; w_s_flush = 1'b0; w_s_vld = 1'b0;
        w_s_rs1_val = 32'h0; w_s_imm = 32'h0; w_s_rs2_val = 64'h0; w_s_is_store = 1'b0;
        w_s_funct3 = 3'd0; w_s_inst_id = 6'd0; w_s_rd = 6'd0; w_s_rd_en = 1'b0; w_s_fp_rd_en = 1'b0;
        test_reset();
        test_load_w();
        test_store_h();
        test_cross();
        test_illegal_d();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
